puckstates_fsm: RTL and testbench
=================================

// Module: puckstates_fsm
// PURPOSE
//  Air-hockey puck engine for a 640x480 field. Tracks puck position, bounces it off
//  top/bottom walls, side walls and both strikers, detects goals and keeps 3-bit scores.
//  Sits between the striker-position/button logic and the VGA renderer / score display.
//  puckstate exposes the current motion state to the renderer and debug.
// PARAMETERS
//  STEP_DIV     1    clocks per movement step (board build sets e.g. 250000)
//  SPEED        1    pixels moved per step, per axis
//  SERVE_STEPS  4    steps puck rests at centre before launch
//  GOAL_TOP     160  goal mouth upper Y (inclusive), both sides
//  GOAL_BOT     320  goal mouth lower Y (inclusive)
//  WIN_SCORE    7    score that ends the game (<=7)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  Lx,Ly      in   11  left striker centre
//  Rx,Ry      in   11  right striker centre
//  Lup,Lmid,Ldown in 1 left deflection select (priority up>mid>down; none = mid)
//  Rup,Rmid,Rdown in 1 right deflection select, same rule
//  Pradius    in   11  puck radius
//  Rradius    in   11  striker radius
//  puckX      out  10  puck centre X (0..639)
//  puckY      out  9   puck centre Y (0..479)
//  puckstate  out  5   motion state code
//  GL,GR      out  3   left / right player score
// BEHAVIOUR
//  - Reset: puckX=320, puckY=240, puckstate=SERVE(0), GL=GR=0, step counter=0, next serve left.
//  - States: 0 SERVE, 1 R_UP, 2 R_FLAT, 3 R_DOWN, 4 L_UP, 5 L_FLAT, 6 L_DOWN,
//    7 GOAL_L (left scored), 8 GOAL_R (right scored), 9 OVER; codes 10..31 -> SERVE next step.
//  - All updates happen on a step pulse (every STEP_DIV clocks); outputs registered, stable between.
//  - Motion: R_* dx=+SPEED, L_* dx=-SPEED; *_UP dy=-SPEED, *_FLAT 0, *_DOWN +SPEED.
//  - SERVE: puck at (320,240); after SERVE_STEPS steps go L_FLAT or R_FLAT per serve flag.
//  - Per moving step, evaluate on current position, first match wins:
//    1 left edge  (puckX-Pradius<=0, moving L): Y in [GOAL_TOP,GOAL_BOT] -> GR+1, GOAL_R;
//      else flip to R_ same vertical. Right edge (puckX+Pradius>=639) mirrored: GL+1, GOAL_L.
//    2 striker hit: |puckX-Lx|<=Pradius+Rradius and |puckY-Ly|<=Pradius+Rradius while moving L
//      -> R_UP/R_FLAT/R_DOWN per L buttons. Right striker mirrored (only while moving R -> L_*).
//      Overlap with a striker while moving away from it is ignored.
//    3 top (puckY-Pradius<=0) flips UP->DOWN; bottom (puckY+Pradius>=479) flips DOWN->UP.
//    Then move by new direction; clamp X to [Pradius,639-Pradius], Y to [Pradius,479-Pradius].
//  - Compare in 12-bit signed arithmetic; positions never wrap.
//  - GOAL_x lasts one step: puck recentred, serve flag set toward the conceding side, ->SERVE;
//    if the incremented score == WIN_SCORE -> OVER instead.
//  - OVER: puck frozen at centre, scores held; only reset leaves it.
//  - Scores saturate at 7. Reset mid-play overrides everything in the same cycle.
// STRUCTURE
//  - Package puck_pkg: state enum/codes, field size 640x480, centre constants.
//  - One sub-module step_tick (counter -> 1-clock step pulse, STEP_DIV); rest is one FSM.
// TESTING
//  - reset=1 then 0 -> puckX=320, puckY=240, puckstate=0, GL=GR=0; after 4 steps state=5,
//    puckX=319 next step.
//  - Serve with Rx=320,Ry=240 overlapping puck -> no right hit (moving L), puck keeps going left.
//  - Lx=160,Ly=240,Pr=5,Rr=13,Lup=1 -> at puckX=178 state becomes 1, puckX then increases.
//  - Ly=0 (striker away), L_FLAT at Y=240 -> at puckX=5 GR=1, state 8, then 0 at (320,240),
//    relaunches as state 5 (serve toward left).
//  - L_FLAT at Y=100 reaching puckX=5 -> state 2, no score; L_UP reaching puckY=5 -> state 6.
//  - Seventh right goal -> GR=7, state 9, puck frozen; reset -> all reset values.

Source files
------------

// File: rtl/puck_pkg.sv
// Shared types and helpers for the air-hockey puck engine: state codes,
// field geometry and small arithmetic helpers used by the motion FSM.
package puck_pkg;

    localparam int FIELD_W  = 640;
    localparam int FIELD_H  = 480;
    localparam int CENTRE_X = FIELD_W / 2;
    localparam int CENTRE_Y = FIELD_H / 2;

    localparam logic signed [11:0] X_MAX = 12'(FIELD_W - 1);
    localparam logic signed [11:0] Y_MAX = 12'(FIELD_H - 1);
    localparam logic signed [11:0] CX    = 12'(CENTRE_X);
    localparam logic signed [11:0] CY    = 12'(CENTRE_Y);

    typedef enum logic [4:0] {
        ST_SERVE  = 5'd0,
        ST_R_UP   = 5'd1,
        ST_R_FLAT = 5'd2,
        ST_R_DOWN = 5'd3,
        ST_L_UP   = 5'd4,
        ST_L_FLAT = 5'd5,
        ST_L_DOWN = 5'd6,
        ST_GOAL_L = 5'd7,
        ST_GOAL_R = 5'd8,
        ST_OVER   = 5'd9
    } puck_state_t;

    typedef enum logic [1:0] {
        V_UP   = 2'd0,
        V_FLAT = 2'd1,
        V_DOWN = 2'd2
    } vert_t;

    function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
        return (v < 12'sd0) ? -v : v;
    endfunction

    function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                   input logic signed [11:0] lo,
                                                   input logic signed [11:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        return v;
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

    // Deflection select: up beats mid beats down; no button behaves as mid.
    function automatic vert_t btn_vert(input logic up, input logic mid, input logic down);
        if (up)
            return V_UP;
        else if (mid)
            return V_FLAT;
        else if (down)
            return V_DOWN;
        return V_FLAT;
    endfunction

    function automatic puck_state_t mk_state(input logic right, input vert_t v);
        puck_state_t s;
        case (v)
            V_UP:    s = right ? ST_R_UP   : ST_L_UP;
            V_DOWN:  s = right ? ST_R_DOWN : ST_L_DOWN;
            default: s = right ? ST_R_FLAT : ST_L_FLAT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/puckstates_fsm_step_tick.sv
// Movement-rate divider: emits a one-clock step pulse every STEP_DIV clocks.
module step_tick #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/puckstates_fsm.sv
// Air-hockey puck engine: moves the puck, resolves wall/striker bounces,
// detects goals and keeps both scores. All state advances on the step pulse.
module puckstates_fsm
    import puck_pkg::*;
#(
    parameter int STEP_DIV    = 1,
    parameter int SPEED       = 1,
    parameter int SERVE_STEPS = 4,
    parameter int GOAL_TOP    = 160,
    parameter int GOAL_BOT    = 320,
    parameter int WIN_SCORE   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Lx,
    input  logic [10:0] Ly,
    input  logic [10:0] Rx,
    input  logic [10:0] Ry,
    input  logic        Lup,
    input  logic        Lmid,
    input  logic        Ldown,
    input  logic        Rup,
    input  logic        Rmid,
    input  logic        Rdown,
    input  logic [10:0] Pradius,
    input  logic [10:0] Rradius,
    output logic [9:0]  puckX,
    output logic [8:0]  puckY,
    output logic [4:0]  puckstate,
    output logic [2:0]  GL,
    output logic [2:0]  GR
);

    localparam logic signed [11:0] SPD  = 12'(SPEED);
    localparam logic signed [11:0] G_TOP = 12'(GOAL_TOP);
    localparam logic signed [11:0] G_BOT = 12'(GOAL_BOT);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_STEPS - 1);
    localparam logic [2:0]  WIN3 = 3'(WIN_SCORE);

    puck_state_t        r_state;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic [2:0]         r_gl;
    logic [2:0]         r_gr;
    logic [15:0]        r_serve_cnt;
    logic               r_serve_left;

    logic               w_tick;

    step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // Everything widened to 12-bit signed so edge tests can go negative.
    logic signed [11:0] w_pr, w_reach;
    logic signed [11:0] w_lx, w_ly, w_rx, w_ry;
    assign w_pr    = {1'b0, Pradius};
    assign w_reach = w_pr + signed'({1'b0, Rradius});
    assign w_lx    = {1'b0, Lx};
    assign w_ly    = {1'b0, Ly};
    assign w_rx    = {1'b0, Rx};
    assign w_ry    = {1'b0, Ry};

    logic w_left_edge, w_right_edge, w_in_goal;
    logic w_hit_l, w_hit_r, w_top, w_bot;
    assign w_left_edge  = (r_x - w_pr) <= 12'sd0;
    assign w_right_edge = (r_x + w_pr) >= X_MAX;
    assign w_in_goal    = (r_y >= G_TOP) && (r_y <= G_BOT);
    assign w_hit_l      = (abs12(r_x - w_lx) <= w_reach) && (abs12(r_y - w_ly) <= w_reach);
    assign w_hit_r      = (abs12(r_x - w_rx) <= w_reach) && (abs12(r_y - w_ry) <= w_reach);
    assign w_top        = (r_y - w_pr) <= 12'sd0;
    assign w_bot        = (r_y + w_pr) >= Y_MAX;

    logic               w_cur_right;
    vert_t              w_cur_v;
    logic               w_dir_right;
    vert_t              w_v;
    logic               w_goal_l;
    logic               w_goal_r;
    puck_state_t        w_next_state;
    logic signed [11:0] w_dy;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;

    always_comb begin
        w_cur_right = 1'b0;
        w_cur_v     = V_FLAT;
        case (r_state)
            ST_R_UP:   begin w_cur_right = 1'b1; w_cur_v = V_UP;   end
            ST_R_FLAT: begin w_cur_right = 1'b1; w_cur_v = V_FLAT; end
            ST_R_DOWN: begin w_cur_right = 1'b1; w_cur_v = V_DOWN; end
            ST_L_UP:   begin w_cur_right = 1'b0; w_cur_v = V_UP;   end
            ST_L_DOWN: begin w_cur_right = 1'b0; w_cur_v = V_DOWN; end
            default:   begin w_cur_right = 1'b0; w_cur_v = V_FLAT; end
        endcase

        w_dir_right = w_cur_right;
        w_v         = w_cur_v;
        w_goal_l    = 1'b0;
        w_goal_r    = 1'b0;

        // Priority: side edge/goal, then striker toward the puck, then top/bottom.
        if (!w_cur_right && w_left_edge) begin
            if (w_in_goal) w_goal_r = 1'b1;
            else           w_dir_right = 1'b1;
        end else if (w_cur_right && w_right_edge) begin
            if (w_in_goal) w_goal_l = 1'b1;
            else           w_dir_right = 1'b0;
        end else if (!w_cur_right && w_hit_l) begin
            w_dir_right = 1'b1;
            w_v         = btn_vert(Lup, Lmid, Ldown);
        end else if (w_cur_right && w_hit_r) begin
            w_dir_right = 1'b0;
            w_v         = btn_vert(Rup, Rmid, Rdown);
        end else if (w_top && w_cur_v == V_UP) begin
            w_v = V_DOWN;
        end else if (w_bot && w_cur_v == V_DOWN) begin
            w_v = V_UP;
        end

        w_next_state = mk_state(w_dir_right, w_v);
        case (w_v)
            V_UP:    w_dy = -SPD;
            V_DOWN:  w_dy = SPD;
            default: w_dy = 12'sd0;
        endcase
        w_nx = clamp12(r_x + (w_dir_right ? SPD : -SPD), w_pr, X_MAX - w_pr);
        w_ny = clamp12(r_y + w_dy, w_pr, Y_MAX - w_pr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SERVE;
            r_x          <= CX;
            r_y          <= CY;
            r_gl         <= 3'd0;
            r_gr         <= 3'd0;
            r_serve_cnt  <= 16'd0;
            r_serve_left <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                ST_SERVE: begin
                    r_x <= CX;
                    r_y <= CY;
                    if (r_serve_cnt == SERVE_LAST) begin
                        r_serve_cnt <= 16'd0;
                        r_state     <= r_serve_left ? ST_L_FLAT : ST_R_FLAT;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + 16'd1;
                    end
                end
                ST_R_UP, ST_R_FLAT, ST_R_DOWN, ST_L_UP, ST_L_FLAT, ST_L_DOWN: begin
                    if (w_goal_r) begin
                        r_gr    <= sat_inc3(r_gr);
                        r_state <= ST_GOAL_R;
                    end else if (w_goal_l) begin
                        r_gl    <= sat_inc3(r_gl);
                        r_state <= ST_GOAL_L;
                    end else begin
                        r_state <= w_next_state;
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                    end
                end
                // Conceding side receives the next serve.
                ST_GOAL_L: begin
                    r_x          <= CX;
                    r_y          <= CY;
                    r_serve_cnt  <= 16'd0;
                    r_serve_left <= 1'b0;
                    r_state      <= (r_gl == WIN3) ? ST_OVER : ST_SERVE;
                end
                ST_GOAL_R: begin
                    r_x          <= CX;
                    r_y          <= CY;
                    r_serve_cnt  <= 16'd0;
                    r_serve_left <= 1'b1;
                    r_state      <= (r_gr == WIN3) ? ST_OVER : ST_SERVE;
                end
                ST_OVER: begin
                    r_x <= CX;
                    r_y <= CY;
                end
                default: begin
                    r_x         <= CX;
                    r_y         <= CY;
                    r_serve_cnt <= 16'd0;
                    r_state     <= ST_SERVE;
                end
            endcase
        end
    end

    assign puckX     = r_x[9:0];
    assign puckY     = r_y[8:0];
    assign puckstate = r_state;
    assign GL        = r_gl;
    assign GR        = r_gr;

endmodule

// File: tb/tb_puckstates_fsm.sv
// Directed bench for puckstates_fsm: serve, goal, striker/wall bounces, game over.
module tb_puckstates_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] Lx = 11'd0, Ly = 11'd0, Rx = 11'd320, Ry = 11'd240;
    logic        Lup = 1'b0, Lmid = 1'b0, Ldown = 1'b0;
    logic        Rup = 1'b0, Rmid = 1'b0, Rdown = 1'b0;
    logic [10:0] Pradius = 11'd5, Rradius = 11'd13;
    logic [9:0]  puckX;
    logic [8:0]  puckY;
    logic [4:0]  puckstate;
    logic [2:0]  GL, GR;

    int vectors = 0;
    int miscompares = 0;

    puckstates_fsm dut (
        .clk(clk), .reset(reset),
        .Lx(Lx), .Ly(Ly), .Rx(Rx), .Ry(Ry),
        .Lup(Lup), .Lmid(Lmid), .Ldown(Ldown),
        .Rup(Rup), .Rmid(Rmid), .Rdown(Rdown),
        .Pradius(Pradius), .Rradius(Rradius),
        .puckX(puckX), .puckY(puckY), .puckstate(puckstate),
        .GL(GL), .GR(GR)
    );

    always #5 clk = ~clk;

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step_n(1);
    endtask

    task automatic release_reset();
        reset = 1'b0;
    endtask

    task automatic wait_x(input int val, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (int'(puckX) == val) found = 1'b1;
            else step_n(1);
        end
    endtask

    task automatic wait_y(input int val, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (int'(puckY) == val) found = 1'b1;
            else step_n(1);
        end
    endtask

    task automatic wait_state(input int val, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (int'(puckstate) == val) found = 1'b1;
            else step_n(1);
        end
    endtask

    task automatic test_reset();
        Lx = 0; Ly = 0; Rx = 320; Ry = 240;
        apply_reset();
        vectors++;
        if (puckX !== 10'd320 || puckY !== 9'd240 || puckstate !== 5'd0 || GL !== 3'd0 || GR !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_values: got x=%0d y=%0d st=%0d GL=%0d GR=%0d expected 320 240 0 0 0",
                     puckX, puckY, puckstate, GL, GR);
        end
        release_reset();
        step_n(3);
        vectors++;
        if (puckstate !== 5'd0 || puckX !== 10'd320) begin
            miscompares++;
            $display("FAIL serve_hold: got st=%0d x=%0d expected 0 320", puckstate, puckX);
        end
        step_n(1);
        vectors++;
        if (puckstate !== 5'd5 || puckX !== 10'd320) begin
            miscompares++;
            $display("FAIL serve_launch: got st=%0d x=%0d expected 5 320", puckstate, puckX);
        end
        $display("reset/serve: st=%0d x=%0d y=%0d", puckstate, puckX, puckY);
    endtask

    task automatic test_serve_overlap();
        step_n(1);
        vectors++;
        if (puckX !== 10'd319 || puckstate !== 5'd5) begin
            miscompares++;
            $display("FAIL first_move: got x=%0d st=%0d expected 319 5", puckX, puckstate);
        end
        step_n(1);
        vectors++;
        if (puckX !== 10'd318 || puckY !== 9'd240 || puckstate !== 5'd5) begin
            miscompares++;
            $display("FAIL overlap_ignored: got x=%0d y=%0d st=%0d expected 318 240 5", puckX, puckY, puckstate);
        end
        $display("serve overlap: st=%0d x=%0d", puckstate, puckX);
    endtask

    task automatic test_goal();
        bit found;
        wait_state(8, found);
        vectors++;
        if (!found || GR !== 3'd1 || GL !== 3'd0) begin
            miscompares++;
            $display("FAIL goal_right: got found=%0d GR=%0d GL=%0d expected 1 1 0", found, GR, GL);
        end
        step_n(1);
        vectors++;
        if (puckstate !== 5'd0 || puckX !== 10'd320 || puckY !== 9'd240) begin
            miscompares++;
            $display("FAIL goal_recentre: got st=%0d x=%0d y=%0d expected 0 320 240", puckstate, puckX, puckY);
        end
        step_n(4);
        vectors++;
        if (puckstate !== 5'd5) begin
            miscompares++;
            $display("FAIL reserve_left: got st=%0d expected 5", puckstate);
        end
        step_n(1);
        vectors++;
        if (puckX !== 10'd319) begin
            miscompares++;
            $display("FAIL reserve_move: got x=%0d expected 319", puckX);
        end
        $display("goal: GR=%0d st=%0d x=%0d", GR, puckstate, puckX);
    endtask

    task automatic test_striker_and_walls();
        bit found;
        Lx = 160; Ly = 240; Lup = 1;
        Rx = 336; Ry = 100; Rmid = 1;
        apply_reset();
        vectors++;
        if (GR !== 3'd0 || puckstate !== 5'd0 || puckX !== 10'd320) begin
            miscompares++;
            $display("FAIL midplay_reset: got GR=%0d st=%0d x=%0d expected 0 0 320", GR, puckstate, puckX);
        end
        release_reset();
        wait_x(178, found);
        step_n(1);
        vectors++;
        if (!found || puckstate !== 5'd1 || puckX !== 10'd179 || puckY !== 9'd239) begin
            miscompares++;
            $display("FAIL left_striker_up: got st=%0d x=%0d y=%0d expected 1 179 239", puckstate, puckX, puckY);
        end
        wait_x(318, found);
        step_n(1);
        vectors++;
        if (!found || puckstate !== 5'd5 || puckX !== 10'd317 || puckY !== 9'd100) begin
            miscompares++;
            $display("FAIL right_striker_flat: got st=%0d x=%0d y=%0d expected 5 317 100", puckstate, puckX, puckY);
        end
        wait_x(5, found);
        step_n(1);
        vectors++;
        if (!found || puckstate !== 5'd2 || puckX !== 10'd6 || GR !== 3'd0 || GL !== 3'd0) begin
            miscompares++;
            $display("FAIL side_wall_bounce: got st=%0d x=%0d GR=%0d GL=%0d expected 2 6 0 0", puckstate, puckX, GR, GL);
        end
        Rmid = 0; Rup = 1;
        wait_x(318, found);
        step_n(1);
        vectors++;
        if (!found || puckstate !== 5'd4 || puckX !== 10'd317 || puckY !== 9'd99) begin
            miscompares++;
            $display("FAIL right_striker_up: got st=%0d x=%0d y=%0d expected 4 317 99", puckstate, puckX, puckY);
        end
        wait_y(5, found);
        step_n(1);
        vectors++;
        if (!found || puckstate !== 5'd6 || puckY !== 9'd6 || puckX !== 10'd222) begin
            miscompares++;
            $display("FAIL top_wall_bounce: got st=%0d x=%0d y=%0d expected 6 222 6", puckstate, puckX, puckY);
        end
        $display("striker/walls: st=%0d x=%0d y=%0d", puckstate, puckX, puckY);
        Lup = 0; Rup = 0;
    endtask

    task automatic test_win();
        bit found;
        Lx = 0; Ly = 0; Rx = 320; Ry = 240;
        apply_reset();
        release_reset();
        for (int g = 1; g <= 7; g++) begin
            wait_state(8, found);
            vectors++;
            if (!found || int'(GR) != g || GL !== 3'd0) begin
                miscompares++;
                $display("FAIL goal_count: got found=%0d GR=%0d GL=%0d expected 1 %0d 0", found, GR, GL, g);
            end
            step_n(1);
            vectors++;
            if (int'(puckstate) != ((g == 7) ? 9 : 0)) begin
                miscompares++;
                $display("FAIL after_goal_state: got %0d expected %0d", puckstate, (g == 7) ? 9 : 0);
            end
            $display("goal %0d: GR=%0d st=%0d", g, GR, puckstate);
        end
        step_n(20);
        vectors++;
        if (puckstate !== 5'd9 || puckX !== 10'd320 || puckY !== 9'd240 || GR !== 3'd7) begin
            miscompares++;
            $display("FAIL over_frozen: got st=%0d x=%0d y=%0d GR=%0d expected 9 320 240 7", puckstate, puckX, puckY, GR);
        end
        apply_reset();
        release_reset();
        vectors++;
        if (puckstate !== 5'd0 || GR !== 3'd0 || GL !== 3'd0 || puckX !== 10'd320) begin
            miscompares++;
            $display("FAIL over_reset: got st=%0d GR=%0d GL=%0d x=%0d expected 0 0 0 320", puckstate, GR, GL, puckX);
        end
        $display("game over + reset: st=%0d GR=%0d", puckstate, GR);
    endtask

    initial begin
        test_reset();
        test_serve_overlap();
        test_goal();
        test_striker_and_walls();
        test_win();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
